wci_ocp_checker: RTL and testbench

- Parametrised, synthesizable WCI::OCP protocol observer; successor to the fixed-width simulation-only monitor.
- Attaches passively to one WCI link alongside initiator and target. Never drives link signals.
- Tracks the single outstanding transaction and measures response latency.
- Counts reads, writes, FAIL/ERR responses and timeouts. Raises sticky protocol-violation flags for use in benches and in on-chip debug.

---
 rtl/wci_ocp_checker.sv | 187 ++++++++++++++++++
 tb/tb_wci_ocp_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wci_ocp_checker.sv
// wci_ocp_checker: passive WCI::OCP link observer. Tracks the single outstanding
// transaction, reports it with its latency, counts events and raises sticky violation flags.
module wci_ocp_checker #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LAT_W          = 11
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                MReset_n,
    input  logic [2:0]          MCmd,
    input  logic                MAddrSpace,
    input  logic [DATA_W/8-1:0] MByteEn,
    input  logic [ADDR_W-1:0]   MAddr,
    input  logic [DATA_W-1:0]   MData,
    input  logic [1:0]          SResp,
    input  logic [DATA_W-1:0]   SData,
    input  logic                SThreadBusy,
    input  logic [1:0]          SFlag,
    input  logic [1:0]          MFlag,
    input  logic                clr,
    output logic [CNT_W-1:0]    wr_count,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    to_count,
    output logic [5:0]          err_flags,
    output logic                busy,
    output logic                txn_valid,
    output logic                txn_is_read,
    output logic                txn_space,
    output logic [ADDR_W-1:0]   txn_addr,
    output logic [DATA_W-1:0]   txn_data,
    output logic [1:0]          txn_resp,
    output logic [LAT_W-1:0]    txn_latency
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WR    = 3'd1;
    localparam logic [2:0] CMD_RD    = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
    state_t state, state_nxt;

    logic [LAT_W-1:0]  lat_cnt;
    logic              cap_is_read, cap_space;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_data;

    logic              stall_vld;
    logic [2:0]        st_cmd;
    logic              st_space;
    logic [ADDR_W-1:0] st_addr;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_data;

    logic       accept, resp_seen, timeout, done, stall_rec, stall_bad;
    logic [5:0] flag_set;

    // Flag-only link signals are intentionally not checked.
    logic unused_flags;
    assign unused_flags = ^{SFlag, MFlag};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Link reset suppresses every event: no acceptance, no completion, no flags.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        resp_seen = 1'b0;
        timeout   = 1'b0;
        stall_rec = 1'b0;
        stall_bad = 1'b0;
        flag_set  = '0;
        if (!MReset_n) begin
            state_nxt = S_IDLE;
        end else begin
            if (state == S_IDLE) begin
                accept      = (MCmd == CMD_WR || MCmd == CMD_RD) && !SThreadBusy;
                stall_rec   = (MCmd != CMD_IDLE) && SThreadBusy;
                flag_set[0] = (SResp != RESP_NULL);
                if (accept) state_nxt = S_WAIT;
            end else begin
                resp_seen   = (SResp != RESP_NULL);
                timeout     = !resp_seen && (lat_cnt == LAT_W'(TIMEOUT_CYCLES));
                flag_set[1] = (MCmd != CMD_IDLE);
                if (resp_seen || timeout) state_nxt = S_IDLE;
            end
            stall_bad = stall_vld &&
                        ((MCmd != st_cmd) || (MAddrSpace != st_space) ||
                         (MAddr != st_addr) || (MByteEn != st_be) ||
                         ((st_cmd == CMD_WR) && (MData != st_data)));
            flag_set[2] = timeout;
            flag_set[3] = (MCmd > CMD_RD);
            flag_set[4] = stall_bad;
            flag_set[5] = accept && (MByteEn == '0);
        end
    end

    assign done = resp_seen || timeout;
    assign busy = (state == S_WAIT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            lat_cnt     <= '0;
            cap_is_read <= 1'b0;
            cap_space   <= 1'b0;
            cap_addr    <= '0;
            cap_data    <= '0;
            stall_vld   <= 1'b0;
            st_cmd      <= CMD_IDLE;
            st_space    <= 1'b0;
            st_addr     <= '0;
            st_be       <= '0;
            st_data     <= '0;
            txn_valid   <= 1'b0;
            txn_is_read <= 1'b0;
            txn_space   <= 1'b0;
            txn_addr    <= '0;
            txn_data    <= '0;
            txn_resp    <= RESP_NULL;
            txn_latency <= '0;
        end else begin
            state     <= state_nxt;
            stall_vld <= stall_rec;
            if (stall_rec) begin
                st_cmd   <= MCmd;
                st_space <= MAddrSpace;
                st_addr  <= MAddr;
                st_be    <= MByteEn;
                st_data  <= MData;
            end
            if (accept) begin
                cap_is_read <= (MCmd == CMD_RD);
                cap_space   <= MAddrSpace;
                cap_addr    <= MAddr;
                cap_data    <= MData;
                lat_cnt     <= LAT_W'(1);
            end else if (state == S_WAIT && !done) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
            txn_valid <= done;
            if (done) begin
                txn_is_read <= cap_is_read;
                txn_space   <= cap_space;
                txn_addr    <= cap_addr;
                txn_data    <= cap_is_read ? SData : cap_data;
                txn_resp    <= SResp;
                txn_latency <= lat_cnt;
            end
        end
    end

    // Counters and flags; a clear in the same cycle as an event drops the event.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_count   <= '0;
            rd_count   <= '0;
            fail_count <= '0;
            err_count  <= '0;
            to_count   <= '0;
            err_flags  <= '0;
        end else if (clr) begin
            wr_count   <= '0;
            rd_count   <= '0;
            fail_count <= '0;
            err_count  <= '0;
            to_count   <= '0;
            err_flags  <= '0;
        end else begin
            if (accept && MCmd == CMD_WR) wr_count <= sat_inc(wr_count);
            if (accept && MCmd == CMD_RD) rd_count <= sat_inc(rd_count);
            if (resp_seen && SResp == RESP_FAIL) fail_count <= sat_inc(fail_count);
            if (resp_seen && SResp == RESP_ERR) err_count <= sat_inc(err_count);
            if (timeout) to_count <= sat_inc(to_count);
            err_flags <= err_flags | flag_set;
        end
    end
endmodule

// File: tb/tb_wci_ocp_checker.sv
// Directed bench for wci_ocp_checker: transactions, timeout, violations, clear,
// link reset, async reset and counter saturation against hand-computed values.
module tb_wci_ocp_checker;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int TO_CYC = 16;
    localparam int LAT_W  = 5;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic                MReset_n;
    logic [2:0]          MCmd;
    logic                MAddrSpace;
    logic [DATA_W/8-1:0] MByteEn;
    logic [ADDR_W-1:0]   MAddr;
    logic [DATA_W-1:0]   MData;
    logic [1:0]          SResp;
    logic [DATA_W-1:0]   SData;
    logic                SThreadBusy;
    logic [1:0]          SFlag, MFlag;
    logic                clr;
    logic [CNT_W-1:0]    wr_count, rd_count, fail_count, err_count, to_count;
    logic [5:0]          err_flags;
    logic                busy, txn_valid, txn_is_read, txn_space;
    logic [ADDR_W-1:0]   txn_addr;
    logic [DATA_W-1:0]   txn_data;
    logic [1:0]          txn_resp;
    logic [LAT_W-1:0]    txn_latency;

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int valid_snap;

    wci_ocp_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(TO_CYC), .LAT_W(LAT_W)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .MReset_n(MReset_n), .MCmd(MCmd),
        .MAddrSpace(MAddrSpace), .MByteEn(MByteEn), .MAddr(MAddr), .MData(MData),
        .SResp(SResp), .SData(SData), .SThreadBusy(SThreadBusy),
        .SFlag(SFlag), .MFlag(MFlag), .clr(clr),
        .wr_count(wr_count), .rd_count(rd_count), .fail_count(fail_count),
        .err_count(err_count), .to_count(to_count), .err_flags(err_flags),
        .busy(busy), .txn_valid(txn_valid), .txn_is_read(txn_is_read),
        .txn_space(txn_space), .txn_addr(txn_addr), .txn_data(txn_data),
        .txn_resp(txn_resp), .txn_latency(txn_latency)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (txn_valid === 1'b1) valid_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic [2:0] cmd, input logic space,
                             input logic [ADDR_W-1:0] addr, input logic [3:0] be,
                             input logic [DATA_W-1:0] data);
        MCmd = cmd; MAddrSpace = space; MAddr = addr; MByteEn = be; MData = data;
    endtask

    initial begin
        RST_N = 1'b0; MReset_n = 1'b1; clr = 1'b0; SThreadBusy = 1'b0;
        SResp = 2'd0; SData = '0; SFlag = 2'd0; MFlag = 2'd0;
        drive_cmd(3'd0, 1'b0, '0, 4'h0, '0);
        step(16);
        chk("rst_busy", busy, 0);
        chk("rst_valid", txn_valid, 0);
        chk("rst_flags", err_flags, 0);
        chk("rst_wr", wr_count, 0);
        chk("rst_lat", txn_latency, 0);
        RST_N = 1'b1;
        step(2);

        // Write, DVA at latency 3
        drive_cmd(3'd1, 1'b0, 20'h00010, 4'hF, 32'hDEADBEEF);
        step(1);
        MCmd = 3'd0;
        chk("wr_busy", busy, 1);
        chk("wr_cnt_acc", wr_count, 1);
        step(2);
        SResp = 2'd1;
        valid_snap = valid_cnt;
        step(1);
        SResp = 2'd0;
        chk("wr_valid", txn_valid, 1);
        chk("wr_resp", txn_resp, 1);
        chk("wr_lat", txn_latency, 3);
        chk("wr_addr", txn_addr, 20'h00010);
        chk("wr_data", txn_data, 32'hDEADBEEF);
        chk("wr_isrd", txn_is_read, 0);
        chk("wr_busy_end", busy, 0);
        chk("wr_flags", err_flags, 0);
        step(2);
        chk("wr_valid_once", valid_cnt - valid_snap, 1);

        // Config read held through a 4-cycle stall, FAIL at latency 1
        drive_cmd(3'd2, 1'b1, 20'h0FFFC, 4'hF, 32'h0);
        SThreadBusy = 1'b1;
        step(4);
        chk("rd_stall_busy", busy, 0);
        chk("rd_stall_cnt", rd_count, 0);
        SThreadBusy = 1'b0;
        step(1);
        MCmd = 3'd0; SResp = 2'd2; SData = 32'h12345678;
        step(1);
        SResp = 2'd0; SData = '0;
        chk("rd_valid", txn_valid, 1);
        chk("rd_cnt", rd_count, 1);
        chk("rd_fail_cnt", fail_count, 1);
        chk("rd_data", txn_data, 32'h12345678);
        chk("rd_resp", txn_resp, 2);
        chk("rd_lat", txn_latency, 1);
        chk("rd_space", txn_space, 1);
        chk("rd_isrd", txn_is_read, 1);
        chk("rd_addr", txn_addr, 20'h0FFFC);
        chk("rd_flags", err_flags, 0);

        // Read with no response: timeout at latency 16
        drive_cmd(3'd2, 1'b0, 20'h00100, 4'hF, 32'h0);
        step(1);
        MCmd = 3'd0;
        step(15);
        chk("to_busy_before", busy, 1);
        chk("to_valid_before", txn_valid, 0);
        step(1);
        chk("to_valid", txn_valid, 1);
        chk("to_resp", txn_resp, 0);
        chk("to_lat", txn_latency, 16);
        chk("to_cnt", to_count, 1);
        chk("to_flags", err_flags, 6'h04);
        chk("to_busy", busy, 0);

        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr1_flags", err_flags, 0);
        chk("clr1_to", to_count, 0);

        // Unstable stall, idle response, illegal command
        drive_cmd(3'd1, 1'b0, 20'h00020, 4'hF, 32'h1);
        SThreadBusy = 1'b1;
        step(1);
        MAddr = 20'h00024;
        step(1);
        chk("stall_flag", err_flags, 6'h10);
        MCmd = 3'd0; SThreadBusy = 1'b0;
        step(1);
        SResp = 2'd1;
        step(1);
        SResp = 2'd0; MCmd = 3'd5;
        step(1);
        MCmd = 3'd0;
        step(1);
        chk("viol_flags", err_flags, 6'h19);
        chk("viol_wr", wr_count, 0);
        chk("viol_busy", busy, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr2_flags", err_flags, 0);
        chk("clr2_rd", rd_count, 0);
        chk("clr2_fail", fail_count, 0);

        // Clear coinciding with acceptance drops the count but not the transaction
        drive_cmd(3'd1, 1'b0, 20'h00040, 4'hF, 32'hA5A5A5A5);
        clr = 1'b1;
        step(1);
        clr = 1'b0; MCmd = 3'd0;
        chk("clrwin_wr", wr_count, 0);
        chk("clrwin_busy", busy, 1);
        SResp = 2'd3;
        step(1);
        SResp = 2'd0;
        chk("clrwin_valid", txn_valid, 1);
        chk("clrwin_err", err_count, 1);
        chk("clrwin_data", txn_data, 32'hA5A5A5A5);

        // Second read in the response cycle of the first
        drive_cmd(3'd2, 1'b0, 20'h00030, 4'hF, 32'h0);
        step(1);
        MCmd = 3'd0;
        step(1);
        SResp = 2'd1; MCmd = 3'd2; MAddr = 20'h00034;
        step(1);
        SResp = 2'd0; MCmd = 3'd0;
        chk("ovl_valid", txn_valid, 1);
        chk("ovl_lat", txn_latency, 2);
        chk("ovl_addr", txn_addr, 20'h00030);
        chk("ovl_flags", err_flags, 6'h02);
        chk("ovl_rd", rd_count, 1);
        step(1);
        chk("ovl_busy", busy, 0);

        // Link reset while waiting: transaction discarded silently
        drive_cmd(3'd2, 1'b0, 20'h00050, 4'hF, 32'h0);
        step(1);
        MCmd = 3'd0;
        chk("mrst_busy_pre", busy, 1);
        chk("mrst_rd", rd_count, 2);
        step(1);
        valid_snap = valid_cnt;
        MReset_n = 1'b0; SResp = 2'd1;
        step(1);
        MReset_n = 1'b1; SResp = 2'd0;
        chk("mrst_busy", busy, 0);
        step(2);
        chk("mrst_novalid", valid_cnt - valid_snap, 0);
        chk("mrst_flags", err_flags, 6'h02);
        chk("mrst_rd_kept", rd_count, 2);

        // Async reset mid-transaction
        drive_cmd(3'd2, 1'b0, 20'h00060, 4'hF, 32'h0);
        step(1);
        MCmd = 3'd0;
        chk("arst_busy_pre", busy, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd", rd_count, 0);
        chk("arst_flags", err_flags, 0);
        step(2);
        RST_N = 1'b1;
        step(1);

        // Saturation: 19 writes on a 4-bit counter
        for (int i = 1; i <= 19; i++) begin
            drive_cmd(3'd1, 1'b0, ADDR_W'(i * 4), 4'hF, DATA_W'(i));
            step(1);
            MCmd = 3'd0; SResp = 2'd1;
            step(1);
            SResp = 2'd0;
            if (i == 15) chk("sat_wr15", wr_count, 15);
        end
        chk("sat_wr19", wr_count, 15);
        chk("sat_flags", err_flags, 0);

        // Accepted write with no byte enables
        drive_cmd(3'd1, 1'b0, 20'h00080, 4'h0, 32'h0);
        step(1);
        MCmd = 3'd0; SResp = 2'd1;
        step(1);
        SResp = 2'd0;
        chk("be0_flags", err_flags, 6'h20);
        chk("be0_wr", wr_count, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
